// File: rtl/dma_arbiter.sv
// rtl/dma_arbiter.sv - round-robin arbiter sharing one DMA engine among NREQ requesters
// Latches the winner's descriptors, pulses s_dma, waits for f_dma, returns done; keeps perf counters.
module dma_arbiter #(
    parameter int NREQ = 4,
    parameter int OPW  = 3,
    parameter int IW   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*OPW-1:0]  req_op,
    input  logic [NREQ*IW-1:0]   req_info1,
    input  logic [NREQ*IW-1:0]   req_mem_info1,
    input  logic [NREQ*IW-1:0]   req_info2,
    input  logic [NREQ*IW-1:0]   req_mem_info2,
    output logic [NREQ-1:0]      done,
    output logic [NREQ-1:0]      grant,
    output logic                 s_dma,
    output logic [OPW-1:0]       dma_op,
    output logic [IW-1:0]        dma_info1,
    output logic [IW-1:0]        dma_mem_info1,
    output logic [IW-1:0]        dma_info2,
    output logic [IW-1:0]        dma_mem_info2,
    input  logic                 f_dma,
    output logic                 busy,
    output logic [63:0]          cnt_busy,
    output logic [63:0]          cnt_stall
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t            r_state;
    logic [PW-1:0]     r_ptr;
    logic [PW-1:0]     r_gidx;
    logic [NREQ-1:0]   r_grant;
    logic [NREQ-1:0]   r_done;
    logic              r_s_dma;
    logic [OPW-1:0]    r_op;
    logic [IW-1:0]     r_info1;
    logic [IW-1:0]     r_mem_info1;
    logic [IW-1:0]     r_info2;
    logic [IW-1:0]     r_mem_info2;
    logic [63:0]       r_cnt_busy;
    logic [63:0]       r_cnt_stall;

    logic              w_found;
    logic [PW-1:0]     w_g;
    logic [PW-1:0]     w_idx;
    logic [OPW-1:0]    w_op;
    logic [IW-1:0]     w_info1;
    logic [IW-1:0]     w_mem_info1;
    logic [IW-1:0]     w_info2;
    logic [IW-1:0]     w_mem_info2;

    // Scan farthest-first so the candidate closest to r_ptr is the last to overwrite w_g.
    always_comb begin
        w_found = 1'b0;
        w_g     = '0;
        w_idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_idx = PW'((int'(r_ptr) + k) % NREQ);
            if (req[w_idx]) begin
                w_found = 1'b1;
                w_g     = w_idx;
            end
        end
    end

    always_comb begin
        w_op        = '0;
        w_info1     = '0;
        w_mem_info1 = '0;
        w_info2     = '0;
        w_mem_info2 = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_g == PW'(i)) begin
                w_op        = req_op[i*OPW +: OPW];
                w_info1     = req_info1[i*IW +: IW];
                w_mem_info1 = req_mem_info1[i*IW +: IW];
                w_info2     = req_info2[i*IW +: IW];
                w_mem_info2 = req_mem_info2[i*IW +: IW];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_gidx      <= '0;
            r_grant     <= '0;
            r_done      <= '0;
            r_s_dma     <= 1'b0;
            r_op        <= '0;
            r_info1     <= '0;
            r_mem_info1 <= '0;
            r_info2     <= '0;
            r_mem_info2 <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_gidx      <= w_g;
                        r_grant     <= NREQ'(1) << w_g;
                        r_s_dma     <= 1'b1;
                        r_op        <= w_op;
                        r_info1     <= w_info1;
                        r_mem_info1 <= w_mem_info1;
                        r_info2     <= w_info2;
                        r_mem_info2 <= w_mem_info2;
                        r_state     <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_s_dma <= 1'b0;
                    if (f_dma) begin
                        r_done  <= r_grant;
                        r_ptr   <= (r_gidx == PW'(NREQ - 1)) ? '0 : r_gidx + PW'(1);
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= '0;
                    r_grant <= '0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt_busy  <= '0;
            r_cnt_stall <= '0;
        end else begin
            if (r_state == S_BUSY)
                r_cnt_busy <= r_cnt_busy + 64'd1;
            if (|(req & ~r_grant))
                r_cnt_stall <= r_cnt_stall + 64'd1;
        end
    end

    assign done          = r_done;
    assign grant         = r_grant;
    assign s_dma         = r_s_dma;
    assign dma_op        = r_op;
    assign dma_info1     = r_info1;
    assign dma_mem_info1 = r_mem_info1;
    assign dma_info2     = r_info2;
    assign dma_mem_info2 = r_mem_info2;
    assign busy          = (r_state != S_IDLE);
    assign cnt_busy      = r_cnt_busy;
    assign cnt_stall     = r_cnt_stall;

endmodule

// File: tb/tb_dma_arbiter.sv
// tb/tb_dma_arbiter.sv - directed self-checking bench for dma_arbiter
module tb_dma_arbiter;
    localparam int NREQ = 4;
    localparam int OPW  = 3;
    localparam int IW   = 32;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NREQ-1:0]     req = '0;
    logic [NREQ*OPW-1:0] req_op = '0;
    logic [NREQ*IW-1:0]  req_info1 = '0;
    logic [NREQ*IW-1:0]  req_mem_info1 = '0;
    logic [NREQ*IW-1:0]  req_info2 = '0;
    logic [NREQ*IW-1:0]  req_mem_info2 = '0;
    logic [NREQ-1:0]     done;
    logic [NREQ-1:0]     grant;
    logic                s_dma;
    logic [OPW-1:0]      dma_op;
    logic [IW-1:0]       dma_info1;
    logic [IW-1:0]       dma_mem_info1;
    logic [IW-1:0]       dma_info2;
    logic [IW-1:0]       dma_mem_info2;
    logic                f_dma = 1'b0;
    logic                busy;
    logic [63:0]         cnt_busy;
    logic [63:0]         cnt_stall;

    int vec  = 0;
    int errs = 0;
    logic prev_s = 1'b0;

    dma_arbiter #(.NREQ(NREQ), .OPW(OPW), .IW(IW)) dut (
        .clk(clk), .rst(rst), .req(req), .req_op(req_op),
        .req_info1(req_info1), .req_mem_info1(req_mem_info1),
        .req_info2(req_info2), .req_mem_info2(req_mem_info2),
        .done(done), .grant(grant), .s_dma(s_dma), .dma_op(dma_op),
        .dma_info1(dma_info1), .dma_mem_info1(dma_mem_info1),
        .dma_info2(dma_info2), .dma_mem_info2(dma_mem_info2),
        .f_dma(f_dma), .busy(busy), .cnt_busy(cnt_busy), .cnt_stall(cnt_stall)
    );

    always #5 clk = ~clk;

    // s_dma never repeats on consecutive cycles and never coincides with done
    always @(negedge clk) begin
        if (rst) begin
            prev_s = 1'b0;
        end else begin
            vec++;
            if (s_dma && (prev_s || done != '0)) begin
                errs++;
                $display("FAIL s_dma_exclusive got s_dma=%b prev=%b done=%b exp no overlap", s_dma, prev_s, done);
            end
            prev_s = s_dma;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired exp finish before timeout");
        $fatal(1);
    end

    task automatic set_all_payload();
        for (int i = 0; i < NREQ; i++) begin
            req_op[i*OPW +: OPW]       = OPW'(i + 1);
            req_info1[i*IW +: IW]      = 32'h100 + i;
            req_mem_info1[i*IW +: IW]  = 32'h200 + i;
            req_info2[i*IW +: IW]      = 32'h300 + i;
            req_mem_info2[i*IW +: IW]  = 32'h400 + i;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk); req = '0; f_dma = 1'b0; rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    // Returns the number of negedges until s_dma is seen, 0 on timeout.
    task automatic wait_start(output int n);
        n = 0;
        for (int c = 1; c <= 40 && n == 0; c++) begin
            @(negedge clk);
            if (s_dma) n = c;
        end
    endtask

    // Called in the s_dma cycle; f_dma lands lat cycles later; returns in the DONE cycle.
    task automatic pulse_fdma(input int lat);
        repeat (lat) @(negedge clk);
        f_dma = 1'b1;
        @(negedge clk);
        f_dma = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk); @(negedge clk);
        vec++; if (grant !== 4'b0) begin errs++; $display("FAIL reset_grant got=%b exp=0000", grant); end
        vec++; if (done !== 4'b0) begin errs++; $display("FAIL reset_done got=%b exp=0000", done); end
        vec++; if (s_dma !== 1'b0) begin errs++; $display("FAIL reset_s_dma got=%b exp=0", s_dma); end
        vec++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got=%b exp=0", busy); end
        vec++; if (cnt_busy !== 64'd0 || cnt_stall !== 64'd0) begin errs++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", cnt_busy, cnt_stall); end
        vec++; if (dma_op !== 3'd0 || dma_info1 !== 32'd0) begin errs++; $display("FAIL reset_desc got=%h/%h exp=0/0", dma_op, dma_info1); end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_single();
        int n;
        req_op[0 +: OPW] = 3'd1;
        req_info1[0 +: IW] = 32'd5;
        req = 4'b0001;
        wait_start(n);
        vec++; if (n != 1) begin errs++; $display("FAIL single_latency got=%0d exp=1", n); end
        vec++; if (grant !== 4'b0001) begin errs++; $display("FAIL single_grant got=%b exp=0001", grant); end
        vec++; if (dma_op !== 3'd1 || dma_info1 !== 32'd5) begin errs++; $display("FAIL single_desc got=%h/%h exp=1/5", dma_op, dma_info1); end
        vec++; if (busy !== 1'b1) begin errs++; $display("FAIL single_busy got=%b exp=1", busy); end
        pulse_fdma(10);
        vec++; if (done !== 4'b0001) begin errs++; $display("FAIL single_done got=%b exp=0001", done); end
        vec++; if (cnt_busy !== 64'd11) begin errs++; $display("FAIL single_cnt_busy got=%0d exp=11", cnt_busy); end
        req = 4'b0000;
        @(negedge clk);
        vec++; if (done !== 4'b0 || grant !== 4'b0 || busy !== 1'b0) begin errs++; $display("FAIL single_idle got done=%b grant=%b busy=%b exp 0000/0000/0", done, grant, busy); end
    endtask

    task automatic test_all_requesting();
        int n;
        logic [NREQ-1:0] eg;
        apply_reset();
        set_all_payload();
        req = 4'b1111;
        for (int k = 0; k < NREQ; k++) begin
            wait_start(n);
            eg = NREQ'(1) << k;
            vec++; if (n != ((k == 0) ? 1 : 2)) begin errs++; $display("FAIL all_spacing[%0d] got=%0d exp=%0d", k, n, (k == 0) ? 1 : 2); end
            vec++; if (grant !== eg) begin errs++; $display("FAIL all_grant[%0d] got=%b exp=%b", k, grant, eg); end
            vec++; if (dma_op !== OPW'(k + 1) || dma_info1 !== 32'h100 + k || dma_mem_info1 !== 32'h200 + k || dma_info2 !== 32'h300 + k || dma_mem_info2 !== 32'h400 + k) begin
                errs++; $display("FAIL all_desc[%0d] got=%h/%h/%h/%h/%h exp op=%0d base+%0d", k, dma_op, dma_info1, dma_mem_info1, dma_info2, dma_mem_info2, k + 1, k);
            end
            pulse_fdma(1 + k);
            vec++; if (done !== eg) begin errs++; $display("FAIL all_done[%0d] got=%b exp=%b", k, done, eg); end
            req[k] = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic test_fairness();
        int n;
        int exp_g[4] = '{0, 2, 0, 2};
        logic [NREQ-1:0] eg;
        req = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            wait_start(n);
            eg = NREQ'(1) << exp_g[k];
            vec++; if (n == 0 || grant !== eg) begin errs++; $display("FAIL fair_grant[%0d] got=%b exp=%b", k, grant, eg); end
            pulse_fdma(1);
            vec++; if (done !== eg) begin errs++; $display("FAIL fair_done[%0d] got=%b exp=%b", k, done, eg); end
        end
        req = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_payload_isolation();
        int n;
        req_op[1*OPW +: OPW] = 3'd5;
        req_info1[1*IW +: IW] = 32'hAAAA_0001;
        req = 4'b0010;
        wait_start(n);
        vec++; if (n != 1 || grant !== 4'b0010) begin errs++; $display("FAIL iso_grant got=%b exp=0010", grant); end
        req_op[1*OPW +: OPW] = 3'd7;
        req_info1[1*IW +: IW] = 32'hDEAD_BEEF;
        req[3] = 1'b0;
        @(negedge clk); @(negedge clk);
        vec++; if (dma_op !== 3'd5 || dma_info1 !== 32'hAAAA_0001) begin errs++; $display("FAIL iso_hold got=%h/%h exp=5/aaaa0001", dma_op, dma_info1); end
        pulse_fdma(1);
        vec++; if (done !== 4'b0010) begin errs++; $display("FAIL iso_done got=%b exp=0010", done); end
        req = 4'b0000;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); f_dma = 1'b1;
            @(negedge clk); f_dma = 1'b0;
            vec++; if (done !== 4'b0 || busy !== 1'b0 || grant !== 4'b0) begin errs++; $display("FAIL iso_spurious[%0d] got done=%b busy=%b exp 0000/0", c, done, busy); end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        req = 4'b0001;
        wait_start(n);
        vec++; if (n != 1 || grant !== 4'b0001) begin errs++; $display("FAIL rmid_grant got=%b exp=0001", grant); end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        vec++; if (grant !== 4'b0 || done !== 4'b0 || s_dma !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL rmid_async got grant=%b done=%b s=%b busy=%b exp all 0", grant, done, s_dma, busy); end
        vec++; if (cnt_busy !== 64'd0 || dma_info1 !== 32'd0) begin errs++; $display("FAIL rmid_clear got=%0d/%h exp=0/0", cnt_busy, dma_info1); end
        @(negedge clk);
        rst = 1'b0;
        req = 4'b0101;
        wait_start(n);
        vec++; if (n != 1 || grant !== 4'b0001) begin errs++; $display("FAIL rmid_ptr0 got=%b exp=0001", grant); end
        pulse_fdma(1);
        req = 4'b0100;
        wait_start(n);
        vec++; if (n != 2 || grant !== 4'b0100) begin errs++; $display("FAIL rmid_regrant got=%b n=%0d exp=0100 n=2", grant, n); end
        pulse_fdma(1);
        vec++; if (done !== 4'b0100) begin errs++; $display("FAIL rmid_done got=%b exp=0100", done); end
        req = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_stall();
        int n;
        logic [63:0] s0;
        apply_reset();
        s0 = cnt_stall;
        req = 4'b1010;
        wait_start(n);
        vec++; if (n != 1 || grant !== 4'b0010) begin errs++; $display("FAIL stall_grant1 got=%b exp=0010", grant); end
        pulse_fdma(20);
        vec++; if (done !== 4'b0010) begin errs++; $display("FAIL stall_done1 got=%b exp=0010", done); end
        req[1] = 1'b0;
        wait_start(n);
        vec++; if (n != 2 || grant !== 4'b1000) begin errs++; $display("FAIL stall_grant3 got=%b exp=1000", grant); end
        vec++; if (cnt_stall - s0 !== 64'd24) begin errs++; $display("FAIL stall_count got=%0d exp=24", cnt_stall - s0); end
        pulse_fdma(1);
        req = 4'b0000;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_requesting();
        test_fairness();
        test_payload_isolation();
        test_reset_mid();
        test_stall();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule

// File: doc/dma_arbiter.md
# dma_arbiter

Round-robin arbiter that shares the single DMA engine between up to NREQ requesters: the main layer controller and auxiliary loaders/writers. It holds one DMA transfer in flight at a time. It latches the winning requester's opcode and address/loop descriptors, issues the one-cycle DMA start, waits for the DMA finish and returns a one-cycle done to the owner. It sits between the requesters and the DMA engine and keeps cycle counters for performance measurement.

## Interface
- NREQ, 4: number of requesters; 2..8.
- OPW, 3: DMA opcode width.
- IW, 32: width of each descriptor word.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NREQ  level request; held high with payload stable until matching done.
- req_op  in  NREQ*OPW  opcode per requester; requester i owns slice [i*OPW +: OPW].
- req_info1, req_mem_info1, req_info2, req_mem_info2  in  NREQ*IW each  descriptor words; requester i owns slice [i*IW +: IW].
- done  out  NREQ  one-cycle completion pulse to the owner.
- grant  out  NREQ  one-hot owner of the DMA; zero when free.
- s_dma  out  1  one-cycle DMA start.
- dma_op  out  OPW  registered opcode to the DMA.
- dma_info1, dma_mem_info1, dma_info2, dma_mem_info2  out  IW each  registered descriptors to the DMA.
- f_dma  in  1  DMA finish pulse.
- busy  out  1  high when state is not IDLE.
- cnt_busy  out  64  number of BUSY-state cycles.
- cnt_stall  out  64  number of cycles with a request pending but not granted.

## Operation
- All outputs reset to 0. State resets to IDLE. The round-robin pointer `ptr` resets to 0.
- States:
  - IDLE: if req is nonzero, select the winner g. g is the first index with req set, scanning ptr, ptr+1, … modulo NREQ. On that edge, latch the slices of requester g into dma_op/dma_info*/dma_mem_info*. Set grant to onehot(g), set s_dma to 1 and go to BUSY. Otherwise stay in IDLE.
  - BUSY: s_dma is cleared after its first cycle. Descriptors and grant hold. On f_dma, go to DONE, set done[g] to 1 and set ptr to (g+1) mod NREQ.
  - DONE: done[g] is high for exactly this cycle. Then clear grant and done and go to IDLE.
- f_dma is ignored in IDLE and DONE.
- req of a requester that is not granted has no effect on an in-flight transfer. Payload changes on any requester during BUSY are ignored because the descriptors are latched.
- Requester contract: drop req no later than the edge after it samples done high, i.e. req must be low in the IDLE cycle that follows DONE. Violating this re-grants that requester only if it still wins round-robin.
- cnt_busy increments by 1 in every BUSY cycle.
- cnt_stall increments by 1 in every cycle in which (req & ~grant) is nonzero.
- Both counters wrap modulo 2^64. Both are cleared only by rst.
- When NREQ is not a power of two, ptr wraps from NREQ-1 to 0.
- Reset mid-transfer clears everything immediately, including any pending done. The DMA engine is reset by the same rst.

## Timing
- Request to start: req sampled high in IDLE at cycle t gives s_dma=1, with grant and descriptors valid, at cycle t+1.
- Finish to done: f_dma high at cycle u (BUSY) gives done=1 at u+1 and IDLE at u+2.
- Minimum back-to-back spacing: the next s_dma is at u+3 after f_dma at u.
- Fastest transfer: f_dma arrives in the cycle after s_dma. The total occupancy from req to the next grant opportunity is then 4 cycles.
- s_dma is never high for two consecutive cycles.
- done and s_dma are never high in the same cycle.

## Test plan
- Single request: NREQ=4, req=0001, op=1, info1=5, f_dma 10 cycles after s_dma.
  - s_dma at t+1 with dma_op=1 and dma_info1=5.
  - done=0001 one cycle after f_dma.
  - cnt_busy=11.
- All requesting: req=1111 held, each requester dropping req after its done.
  - Grants occur in order 0001, 0010, 0100, 1000.
  - Each start shows the matching slice's descriptors.
- Fairness: requesters 0 and 2 re-request immediately after done. Grants alternate 0, 2, 0, 2; requester 0 never wins twice in a row while 2 is pending.
- Payload isolation: requester 1 changes its descriptors during BUSY.
  - dma_info* stay at the latched values.
  - Spurious f_dma pulses in IDLE produce no done.
- Reset mid-operation: assert rst during BUSY.
  - All outputs are 0 the same cycle (asynchronous).
  - After release, ptr=0 and a new req=0100 is granted normally.
- Stall counter: requester 1 is granted with a 20-cycle transfer while requester 3 waits.
  - cnt_stall increases by at least 22 before grant=1000.
